// File: rtl/trdb_pkg.sv
// trdb_pkg - shared types and constants for the trace debugger output path.
//   XLEN          : packet word width
//   OVF_TAG       : tag byte placed in the top byte of an overflow marker word
//   sched_state_e : output scheduler states
//   ovf_marker()  : builds an overflow marker word from a lost-word count
package trdb_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [7:0] OVF_TAG = 8'hA5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DROP  = 2'd1,
    MARK  = 2'd2,
    FLUSH = 2'd3
  } sched_state_e;

  // Marker layout: tag in the top byte, lost count (zero-extended) below it.
  function automatic logic [XLEN-1:0] ovf_marker(input logic [XLEN-9:0] lost);
    return {OVF_TAG, lost};
  endfunction

endpackage

// File: rtl/trdb_sync_fifo.sv
// trdb_sync_fifo - single-clock FIFO with show-ahead read.
//   clk_i, rst_ni    : clock, asynchronous active-low reset (pointers only)
//   push_i, wdata_i  : write request and data; refused while full
//   pop_i            : read request; ignored while empty
//   rdata_o          : head word, valid whenever not empty (0 when empty)
//   full_o, empty_o  : status of the current (pre-edge) contents
//   level_o          : occupancy, 0..DEPTH
module trdb_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign level_o = wptr_q - rptr_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Masked when empty so stale storage never shows on the output.
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/trdb_packet_sched.sv
// trdb_packet_sched - buffers the trace packet word stream (no backpressure)
// and drains it to a valid/ready sink. Overflowing words are dropped and
// counted; a software flush drains the buffer and reports completion.
//
// Build option TRDB_OVF_MARKER_EN: when defined, an overflow marker word
// (tag + lost count) is inserted once space frees after a drop burst.
//
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   trace_en_i             : capture enable
//   flush_i                : flush request pulse
//   packet_word_i/_valid_i : input word stream
//   out_word_o/_valid_o    : FIFO head towards the sink
//   out_ready_i            : sink accept
//   fifo_level_o           : FIFO occupancy
//   lost_count_o           : dropped words not yet reported (saturating)
//   overflow_o             : sticky overflow flag
//   flush_done_o           : one-cycle flush completion pulse
module trdb_packet_sched
  import trdb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LOSTW      = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          trace_en_i,
  input  logic                          flush_i,
  input  logic [XLEN-1:0]               packet_word_i,
  input  logic                          packet_word_valid_i,
  output logic [XLEN-1:0]               out_word_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic [LOSTW-1:0]              lost_count_o,
  output logic                          overflow_o,
  output logic                          flush_done_o
);

  sched_state_e     state_q, state_d;
  logic             flush_pend_q, flush_pend_d;
  logic [LOSTW-1:0] lost_q, lost_d, lost_inc;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             acc, push, full, empty;
  logic [XLEN-1:0]  push_word;

  function automatic logic [LOSTW-1:0] sat_inc(input logic [LOSTW-1:0] v, input logic inc);
    if (inc && (v != '1)) return v + LOSTW'(1);
    return v;
  endfunction

  assign acc      = trace_en_i && packet_word_valid_i;
  assign lost_inc = sat_inc(lost_q, acc);

  trdb_sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i (push_word),
    .pop_i   (out_valid_o && out_ready_i),
    .rdata_o (out_word_o),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level_o)
  );

  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q | flush_i;
    lost_d       = lost_q;
    ovf_d        = ovf_q;
    done_d       = 1'b0;
    push         = 1'b0;
    push_word    = packet_word_i;
    case (state_q)
      RUN: begin
        if (acc && full) begin
          // Drop takes priority; a pending flush waits until RUN again.
          lost_d  = lost_inc;
          ovf_d   = 1'b1;
          state_d = DROP;
        end else begin
          push = acc;
          if (flush_i || flush_pend_q) begin
            flush_pend_d = 1'b0;
            state_d      = FLUSH;
          end
        end
      end
      DROP: begin
        lost_d = lost_inc;
        if (!full) begin
`ifdef TRDB_OVF_MARKER_EN
          state_d = MARK;
`else
          state_d = RUN;
`endif
        end
      end
`ifdef TRDB_OVF_MARKER_EN
      MARK: begin
        // A word arriving now is dropped but still reported in this marker.
        push      = 1'b1;
        push_word = ovf_marker((XLEN-8)'(lost_inc));
        lost_d    = '0;
        state_d   = RUN;
      end
`endif
      FLUSH: begin
        // Requests during a flush are absorbed.
        flush_pend_d = 1'b0;
        if (empty) begin
          done_d  = 1'b1;
          ovf_d   = 1'b0;
          lost_d  = '0;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= RUN;
      flush_pend_q <= 1'b0;
      lost_q       <= '0;
      ovf_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      lost_q       <= lost_d;
      ovf_q        <= ovf_d;
      done_q       <= done_d;
    end
  end

  assign out_valid_o  = !empty;
  assign lost_count_o = lost_q;
  assign overflow_o   = ovf_q;
  assign flush_done_o = done_q;

endmodule

// File: tb/tb_trdb_packet_sched.sv
// Directed testbench for trdb_packet_sched (FIFO_DEPTH=16, LOSTW=4).
// Expected output words are queued by hand per scenario and compared as the
// sink accepts them. Marker expectations follow TRDB_OVF_MARKER_EN.
module tb_trdb_packet_sched;

`ifdef TRDB_OVF_MARKER_EN
  localparam bit MK = 1'b1;
`else
  localparam bit MK = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        trace_en;
  logic        flush;
  logic [31:0] pword;
  logic        pvalid;
  logic [31:0] out_word;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  level;
  logic [3:0]  lost;
  logic        ovf;
  logic        done;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  trdb_packet_sched #(
    .FIFO_DEPTH (16),
    .LOSTW      (4)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .trace_en_i          (trace_en),
    .flush_i             (flush),
    .packet_word_i       (pword),
    .packet_word_valid_i (pvalid),
    .out_word_o          (out_word),
    .out_valid_o         (out_valid),
    .out_ready_i         (out_ready),
    .fifo_level_o        (level),
    .lost_count_o        (lost),
    .overflow_o          (ovf),
    .flush_done_o        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One clock cycle; any word accepted by the sink in this cycle is compared.
  task automatic cyc();
    if (out_valid && out_ready) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL stream_extra: observed word %08h expected no word", out_word);
      end
      if (exp_q.size() > 0) chk("stream", out_word, exp_q.pop_front());
    end
    @(posedge clk); #1;
  endtask

  task automatic push_words(input logic [31:0] base, input int n);
    for (int j = 0; j < n; j++) begin
      pword  = base + j;
      pvalid = 1'b1;
      cyc();
    end
    pvalid = 1'b0;
  endtask

  task automatic expect_words(input logic [31:0] base, input int n);
    for (int j = 0; j < n; j++) exp_q.push_back(base + j);
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && exp_q.size() > 0; n++) cyc();
    chk("drain_left", exp_q.size(), 0);
    repeat (3) cyc();
    chk("drain_level", level, 0);
  endtask

  task automatic flush_wait();
    bit seen;
    seen  = 1'b0;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      cyc();
      if (done) seen = 1'b1;
    end
    chk("flush_done_seen", seen, 1);
    chk("flush_ovf_clr", ovf, 0);
    chk("flush_lost_clr", lost, 0);
  endtask

  initial begin
    int done_cnt;
    rst_n = 1'b0; trace_en = 1'b0; flush = 1'b0; pword = '0; pvalid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_word", out_word, 0);
    chk("rst_level", level, 0);
    chk("rst_lost", lost, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    cyc();

    // Trickle: each word visible one cycle after input, level stays at 1.
    trace_en = 1'b1; out_ready = 1'b1;
    expect_words(32'h1, 5);
    for (int i = 1; i <= 5; i++) begin
      pword = i; pvalid = 1'b1;
      cyc();
      chk("trickle_valid", out_valid, 1);
      chk("trickle_level", level, 1);
    end
    pvalid = 1'b0;
    cyc();
    chk("trickle_empty", out_valid, 0);
    chk("trickle_lost", lost, 0);
    chk("trickle_left", exp_q.size(), 0);

    // Overflow: 19 words into a stalled 16-deep FIFO.
    out_ready = 1'b0;
    expect_words(32'h100, 16);
    if (MK) exp_q.push_back(32'hA500_0003);
    for (int i = 0; i < 19; i++) begin
      pword = 32'h100 + i; pvalid = 1'b1;
      cyc();
      if (i == 15) begin
        chk("ovf_full_level", level, 16);
        chk("ovf_not_yet", ovf, 0);
      end
      if (i == 16) begin
        chk("ovf_first_drop", ovf, 1);
        chk("ovf_first_lost", lost, 1);
      end
    end
    pvalid = 1'b0;
    cyc(); cyc();
    chk("ovf_lost3", lost, 3);
    chk("ovf_hold_word", out_word, 32'h100);
    out_ready = 1'b1;
    drain();
    chk("ovf_lost_after", lost, MK ? 0 : 3);
    chk("ovf_sticky", ovf, 1);

    // Flush with an empty FIFO: done two cycles after the request.
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("eflush_c1", done, 0);
    cyc();
    chk("eflush_c2", done, 1);
    chk("eflush_ovf", ovf, 0);
    chk("eflush_lost", lost, 0);
    cyc();
    chk("eflush_c3", done, 0);

    // Input held valid while draining: the MARK-cycle word is counted.
    out_ready = 1'b0;
    expect_words(32'h200, 16);
    push_words(32'h200, 18);
    chk("mc_lost2", lost, 2);
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      pword = 32'h300 + j; pvalid = 1'b1;
      cyc();
    end
    pvalid = 1'b0;
    if (MK) exp_q.push_back(32'hA500_0005);
    else    exp_q.push_back(32'h302);
    exp_q.push_back(32'h303);
    drain();
    chk("mc_lost_after", lost, MK ? 0 : 4);
    flush_wait();

    // Flush requested while dropping.
    out_ready = 1'b0;
    expect_words(32'h400, 16);
    push_words(32'h400, 18);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("fd_lost2", lost, 2);
    if (MK) exp_q.push_back(32'hA500_0002);
    out_ready = 1'b1;
    done_cnt = 0;
    for (int n = 0; n < 60; n++) begin
      cyc();
      if (done) done_cnt++;
    end
    chk("fd_done_once", done_cnt, 1);
    chk("fd_left", exp_q.size(), 0);
    chk("fd_ovf", ovf, 0);
    chk("fd_lost", lost, 0);
    chk("fd_level", level, 0);

    // Push and pop together while full: push refused, level 16 -> 15.
    out_ready = 1'b0;
    expect_words(32'h500, 16);
    push_words(32'h500, 16);
    chk("pp_level16", level, 16);
    out_ready = 1'b1;
    pword = 32'h5FF; pvalid = 1'b1;
    cyc();
    pvalid = 1'b0;
    chk("pp_lost1", lost, 1);
    chk("pp_level15", level, 15);
    chk("pp_ovf", ovf, 1);
    if (MK) exp_q.push_back(32'hA500_0001);
    drain();
    flush_wait();

    // Lost counter saturation at 15.
    out_ready = 1'b0;
    expect_words(32'h600, 16);
    push_words(32'h600, 36);
    chk("sat_lost15", lost, 15);
    chk("sat_ovf", ovf, 1);
    if (MK) exp_q.push_back(32'hA500_000F);
    out_ready = 1'b1;
    drain();
    chk("sat_lost_after", lost, MK ? 0 : 15);

    // Asynchronous reset in the middle of a flush.
    out_ready = 1'b0;
    push_words(32'h700, 4);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    cyc(); cyc();
    chk("rf_level4", level, 4);
    chk("rf_no_done", done, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rf_valid", out_valid, 0);
    chk("rf_word", out_word, 0);
    chk("rf_level", level, 0);
    chk("rf_lost", lost, 0);
    chk("rf_ovf", ovf, 0);
    chk("rf_done", done, 0);
    exp_q.delete();
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rf_hold_done", done, 0);
      chk("rf_hold_valid", out_valid, 0);
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("rf_post_done", done, 0);
      chk("rf_post_valid", out_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
